// File: rtl/bist_pkg.sv
// Shared types and default widths for the memory BIST fail logger.
package bist_pkg;

  typedef enum logic {
    ARMED = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int BIST_A_WIDTH = 4;
  localparam int BIST_WIDTH   = 4;

  typedef struct packed {
    logic [BIST_A_WIDTH-1:0] addr;
    logic [BIST_WIDTH-1:0]   exp;
    logic [BIST_WIDTH-1:0]   act;
  } fail_entry_t;

endpackage

// File: rtl/bist_fail_fifo.sv
// First-word-fall-through log FIFO; a push into a full FIFO is accepted only alongside a pop.
module bist_fail_fifo
  import bist_pkg::*;
#(
  parameter type entry_t = fail_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   din,
  output entry_t                   dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     level_q;
  logic            do_push;
  logic            do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;
  assign level   = level_q;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only pointers and level matter.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bist_fail_log.sv
// Captures BIST compare mismatches into a drainable log with fail count and sticky status.
//   state | meaning
//   ARMED | mismatches are counted and logged; bist_done ends the session
//   DONE  | log frozen for capture, reads still drain it; only clear re-arms
module bist_fail_log
  import bist_pkg::*;
#(
  parameter int A_WIDTH   = BIST_A_WIDTH,
  parameter int WIDTH     = BIST_WIDTH,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     cmp_valid,
  input  logic                     is_equal,
  input  logic [A_WIDTH-1:0]       cmp_addr,
  input  logic [WIDTH-1:0]         cmp_exp,
  input  logic [WIDTH-1:0]         cmp_act,
  input  logic                     bist_done,
  output logic                     log_valid,
  input  logic                     log_ready,
  output logic [A_WIDTH-1:0]       log_addr,
  output logic [WIDTH-1:0]         log_exp,
  output logic [WIDTH-1:0]         log_act,
  output logic [$clog2(DEPTH):0]   log_level,
  output logic [CNT_WIDTH-1:0]     fail_cnt,
  output logic                     any_fail,
  output logic                     overflow,
  output logic                     session_done
);

  typedef struct packed {
    logic [A_WIDTH-1:0] addr;
    logic [WIDTH-1:0]   exp;
    logic [WIDTH-1:0]   act;
  } entry_t;

  state_t  state;
  entry_t  head;
  entry_t  wr_entry;
  logic    fail_evt;
  logic    pop_req;
  logic    fifo_full;
  logic    fifo_empty;

  assign fail_evt  = cmp_valid & ~is_equal & (state == ARMED);
  assign log_valid = ~fifo_empty;
  assign pop_req   = log_valid & log_ready;
  assign wr_entry  = '{addr: cmp_addr, exp: cmp_exp, act: cmp_act};

  bist_fail_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (fail_evt),
    .pop   (pop_req),
    .din   (wr_entry),
    .dout  (head),
    .level (log_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stale storage must never leak onto the read port while the log is empty.
  assign log_addr = log_valid ? head.addr : '0;
  assign log_exp  = log_valid ? head.exp  : '0;
  assign log_act  = log_valid ? head.act  : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARMED;
      fail_cnt     <= '0;
      any_fail     <= 1'b0;
      overflow     <= 1'b0;
      session_done <= 1'b0;
    end else if (clear) begin
      state        <= ARMED;
      fail_cnt     <= '0;
      any_fail     <= 1'b0;
      overflow     <= 1'b0;
      session_done <= 1'b0;
    end else begin
      if (fail_evt) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        any_fail <= 1'b1;
        if (fifo_full & ~pop_req) overflow <= 1'b1;
      end
      case (state)
        ARMED: begin
          if (bist_done) begin
            state        <= DONE;
            session_done <= 1'b1;
          end
        end
        DONE:    state <= DONE;
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: doc/bist_fail_log.md
Name: bist_fail_log

Overview:
- Downstream consumer of the memory BIST datapath. Each cycle it samples the compare strobe, the comparator result, the current address, and the expected and actual data words.
- Every mismatch is logged into a small FIFO; the host drains the log through a valid/ready port after or during the run.
- Also keeps a saturating fail count, plus sticky any_fail, overflow and session_done flags for the tester.

Parameters:
- A_WIDTH, 4, address width (matches the BIST address generator)
- WIDTH, 4, data word width (matches memory/data generator)
- DEPTH, 4, log entries; power of 2, >=2
- CNT_WIDTH, 8, width of saturating fail counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear of log, counter, flags, FSM
- cmp_valid  in  1  a compare is performed this cycle
- is_equal  in  1  comparator result, qualified by cmp_valid
- cmp_addr  in  A_WIDTH  address of the compared word
- cmp_exp  in  WIDTH  expected data (data generator compare word)
- cmp_act  in  WIDTH  data read from memory
- bist_done  in  1  end-of-test pulse from BIST controller
- log_valid  out  1  head log entry available
- log_ready  in  1  host consumes head entry
- log_addr  out  A_WIDTH  head entry address
- log_exp  out  WIDTH  head entry expected data
- log_act  out  WIDTH  head entry actual data
- log_level  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- fail_cnt  out  CNT_WIDTH  total mismatches, saturating
- any_fail  out  1  sticky: at least one mismatch seen
- overflow  out  1  sticky: a mismatch was dropped because the log was full
- session_done  out  1  sticky: bist_done seen

Behaviour:
- Reset (rst=1, async): FSM goes to ARMED. log_level, fail_cnt, any_fail, overflow, session_done and log_valid are all 0. Read/write pointers are 0. Storage array is not reset.
- Event definition: event = cmp_valid & ~is_equal & (state==ARMED). is_equal is ignored when cmp_valid=0.
- FSM states:
  - ARMED: events are logged. bist_done=1 -> DONE, session_done=1 on the next edge.
  - DONE: events are ignored and the log is frozen for capture, but reads still drain it. clear -> ARMED. bist_done is ignored.
- Capture timing: an event at edge N writes {cmp_addr, cmp_exp, cmp_act} at wr_ptr. log_valid and log_level reflect it after edge N (1-cycle latency). fail_cnt increments at the same edge; any_fail sets.
- fail_cnt saturates at 2^CNT_WIDTH-1 and never wraps. It counts every event, including dropped ones.
- Read port:
  - First-word-fall-through: log_* show the head entry whenever log_valid=1.
  - Pop on the edge where log_valid & log_ready.
  - When log_valid=0, log_addr, log_exp and log_act are driven to 0.
  - log_ready while empty has no effect.
- Full, no pop: the event is dropped, overflow sets, and the stored log is unchanged.
- Full with pop in the same cycle: the push is accepted and log_level stays DEPTH. overflow does not set.
- Empty with an event and log_ready in the same cycle: the push is accepted and there is no pop; log_level becomes 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty use log_level, not pointer equality.
- clear: synchronous and highest priority. Result is identical to reset except storage contents. An event or pop in the same cycle as clear is discarded.
- bist_done and an event in the same cycle while ARMED: the event is logged, then the FSM enters DONE.
- rst asserted mid-run or mid-drain: everything returns to reset values immediately. Entries are lost.

Decomposition:
- Package bist_pkg holds:
  - state enum {ARMED, DONE}
  - default widths BIST_A_WIDTH=4 and BIST_WIDTH=4
  - a packed struct fail_entry_t {addr, exp, act}
- One natural sub-module, bist_fail_fifo: DEPTH-entry FWFT FIFO of fail_entry_t with push, pop, level and full/empty. The top handles the FSM, event qualification, counter and sticky flags.

Test Plan:
- Reset then idle: rst pulse, cmp_valid=0 for 10 cycles -> all outputs 0, log_valid=0.
- Single fail: cmp_valid=1, is_equal=0, addr=4'h5, exp=4'hA, act=4'h8 for one cycle -> next cycle log_valid=1, log_addr=5, log_exp=A, log_act=8, fail_cnt=1, any_fail=1. log_ready=1 one cycle -> log_valid=0, log_level=0.
- Overflow: 6 fails at addr 0..5 with log_ready=0 -> log_level=4, fail_cnt=6, overflow=1. Draining yields addrs 0,1,2,3 in order.
- Full with simultaneous push+pop: log holding 4 entries, event at addr 9 plus log_ready=1 -> log_level stays 4, overflow stays 0, last drained entry is addr 9.
- Freeze and clear: bist_done pulse, then fails -> session_done=1 and fail_cnt unchanged. clear -> all 0, state ARMED, new fail logged.
- Saturation and reset mid-run: CNT_WIDTH=3, 10 fails -> fail_cnt=7. Async rst asserted between edges -> outputs 0 before the next edge.
